miriscv_lsu: RTL and testbench
==============================

Name: miriscv_lsu

Overview:
- Load/store unit on the core side of the data-memory interface (mem_req/mem_we/mem_size/mem_addr/mem_data).
- Accepts one load/store per instruction from the decoder/datapath, checks size legality and alignment, and drives the memory bus for a fixed response latency.
- Stalls the pipeline until the access completes and captures the already-extended read data for writeback.

Parameters:
- MEM_LATENCY, 1: clock cycles mem_req_o is held before mem_data_i is sampled; legal range 1..15.
- CNT_W, 4: width of the latency counter; must satisfy 2^CNT_W > MEM_LATENCY.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- lsu_req_i  input  1  load/store instruction present; held stable by the core while stall_req_o=1.
- lsu_we_i  input  1  1=store, 0=load.
- lsu_size_i  input  3  0=B, 1=H, 2=W, 4=BU, 5=HU.
- lsu_addr_i  input  32  byte address.
- lsu_data_i  input  32  store data, right-aligned.
- lsu_data_o  output  32  last load result.
- lsu_exc_o  output  1  misaligned or illegal access; combinational.
- stall_req_o  output  1  pipeline stall request; combinational.
- mem_req_o  output  1  memory enable.
- mem_we_o  output  1  memory write enable.
- mem_size_o  output  3  size code to memory.
- mem_addr_o  output  32  address to memory.
- mem_data_o  output  32  write data, masked to size.
- mem_data_i  input  32  read data from memory, already sign/zero-extended by the memory.

Behaviour:
- FSM states: IDLE, BUSY, DONE. Reset state is IDLE.
- Reset values: mem_req_o=0, mem_we_o=0, mem_size_o=0, mem_addr_o=0, mem_data_o=0, lsu_data_o=0, counter=0.
- An access is illegal when either condition holds:
  - size is 3, 6 or 7;
  - the access is a store with size 4 or 5.
- An access is misaligned when either condition holds:
  - H/HU with addr[0]=1;
  - W with addr[1:0]!=0.
- lsu_exc_o = (state==IDLE) && lsu_req_i && (illegal || misaligned). Otherwise lsu_exc_o=0.
- IDLE, lsu_req_i=1, no exception:
  - stall_req_o=1.
  - At the clock edge, latch we, size and addr into the mem_* registers.
  - Latch mem_data_o, masked to size: B gives {24'b0,data[7:0]}, H gives {16'b0,data[15:0]}, W gives data.
  - Set mem_req_o=1, load counter with MEM_LATENCY-1, go to BUSY.
- IDLE with an exception: stall_req_o=0, no bus activity, stay in IDLE. The core traps.
- IDLE with lsu_req_i=0: stall_req_o=0, stay in IDLE.
- BUSY:
  - stall_req_o=1, mem_req_o=1.
  - All mem_* outputs are stable.
  - The counter decrements each cycle.
- BUSY with counter==0, at the clock edge:
  - For a load, lsu_data_o <= mem_data_i.
  - For a store, lsu_data_o is unchanged.
  - mem_req_o <= 0, mem_we_o <= 0, go to DONE.
- DONE:
  - stall_req_o=0, so the core retires the instruction this cycle.
  - lsu_data_o holds the result.
  - Next state is IDLE unconditionally. The request in the DONE cycle is the same instruction and is ignored.
- Latency: one access occupies 2+MEM_LATENCY cycles and stalls for 1+MEM_LATENCY of them.
- mem_we_o is asserted only while mem_req_o=1.
- When idle, mem_addr_o, mem_size_o and mem_data_o hold their last values.
- Back-to-back accesses: an access is accepted in the IDLE cycle directly after DONE.
- Reset mid-access: mem_req_o and mem_we_o drop to 0 immediately (asynchronous). State goes to IDLE. No partial write is issued after reset deasserts.
- lsu_data_o is not updated on exception or on store.

Optional Feature:
- Macro: MIRISCV_LSU_MISALIGN_CHECK_EN.
- Defined: alignment checking as above.
- Undefined:
  - The misaligned term is constant 0, and misaligned accesses proceed to memory unchanged.
  - The illegal-size check remains.

Decomposition:
- miriscv_pkg holds:
  - size localparams LDST_B=3'd0, LDST_H=3'd1, LDST_W=3'd2, LDST_BU=3'd4, LDST_HU=3'd5;
  - FSM state encodings LSU_IDLE, LSU_BUSY, LSU_DONE (2 bits);
  - default MEM_LATENCY.
- One sub-module is natural: miriscv_lsu_chk.
  - Purely combinational.
  - Inputs: size, we, addr[1:0].
  - Outputs: illegal, misaligned, and the store byte mask/data.
  - It is reused by the top-level exception logic.

Test Plan:
- Word load, MEM_LATENCY=1: addr=0x8, size=2, memory returns 0xDEADBEEF.
  - stall_req_o=1 for 2 cycles; mem_req_o=1 for 1 cycle.
  - lsu_data_o=0xDEADBEEF in DONE; stall_req_o=0 in DONE.
- Byte store: size=0, data=0x12345678, addr=0x4.
  - mem_we_o=1 with mem_data_o=0x00000078, mem_size_o=0.
  - lsu_data_o unchanged.
- Misaligned: size=2, addr=0x6.
  - lsu_exc_o=1, stall_req_o=0, mem_req_o stays 0.
  - With the macro undefined: a normal access to 0x6, lsu_exc_o=0.
- Illegal store: we=1, size=4.
  - lsu_exc_o=1, no bus request.
  - The same with size=7 on a load.
- MEM_LATENCY=3: load HU at addr=0x2.
  - mem_req_o=1 for exactly 3 cycles; stall for 4 cycles.
  - Data sampled on the 3rd BUSY edge.
  - The next access is accepted in the cycle after DONE.
- Reset asserted in the 2nd BUSY cycle of a store.
  - mem_req_o and mem_we_o drop to 0 in the same cycle.
  - State is IDLE after release; no further write is issued.

Source files
------------

// File: rtl/miriscv_pkg.sv
// Shared encodings for the miriscv load/store unit: access sizes, LSU FSM states, defaults.
package miriscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned MEM_LATENCY_DEFAULT = 1;

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_BUSY = 2'd1,
    LSU_DONE = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/miriscv_lsu_chk.sv
// Combinational legality/alignment check and store-data masking for one LSU access.
// Alignment checking is compiled in only when MIRISCV_LSU_MISALIGN_CHECK_EN is defined.
module miriscv_lsu_chk
  import miriscv_pkg::*;
(
  input  logic [2:0]      size,
  input  logic            we,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] store_data,
  output logic            illegal,
  output logic            misaligned,
  output logic [3:0]      byte_mask,
  output logic [XLEN-1:0] store_data_masked
);

  // Unsigned sizes exist only for loads; codes 3, 6 and 7 are never legal.
  always_comb begin
    illegal = 1'b0;
    case (size)
      LDST_B, LDST_H, LDST_W: illegal = 1'b0;
      LDST_BU, LDST_HU:       illegal = we;
      default:                illegal = 1'b1;
    endcase
  end

`ifdef MIRISCV_LSU_MISALIGN_CHECK_EN
  always_comb begin
    misaligned = 1'b0;
    if ((size == LDST_H) || (size == LDST_HU))
      misaligned = addr_lo[0];
    else if (size == LDST_W)
      misaligned = (addr_lo != 2'b00);
  end
`else
  logic unused_addr_lo;
  assign unused_addr_lo = ^addr_lo;
  assign misaligned     = 1'b0;
`endif

  always_comb begin
    byte_mask = 4'b1111;
    case (size[1:0])
      2'd0:    byte_mask = 4'b0001;
      2'd1:    byte_mask = 4'b0011;
      default: byte_mask = 4'b1111;
    endcase
  end

  assign store_data_masked = store_data & {{8{byte_mask[3]}}, {8{byte_mask[2]}},
                                           {8{byte_mask[1]}}, {8{byte_mask[0]}}};

endmodule

// File: rtl/miriscv_lsu.sv
// Load/store unit: checks each access, drives the data-memory bus for MEM_LATENCY cycles and
// stalls the pipeline until the result is captured. Optional macro: MIRISCV_LSU_MISALIGN_CHECK_EN.
module miriscv_lsu
  import miriscv_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = MEM_LATENCY_DEFAULT,
  parameter int unsigned CNT_W       = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            lsu_req_i,
  input  logic            lsu_we_i,
  input  logic [2:0]      lsu_size_i,
  input  logic [XLEN-1:0] lsu_addr_i,
  input  logic [XLEN-1:0] lsu_data_i,
  output logic [XLEN-1:0] lsu_data_o,
  output logic            lsu_exc_o,
  output logic            stall_req_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [2:0]      mem_size_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_data_o,
  input  logic [XLEN-1:0] mem_data_i
);

  lsu_state_e       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             mem_req_next, mem_we_next;
  logic [2:0]       mem_size_next;
  logic [XLEN-1:0]  mem_addr_next, mem_data_next, lsu_data_next;

  logic             illegal, misaligned;
  logic [3:0]       unused_store_be;
  logic [XLEN-1:0]  store_data_masked;

  miriscv_lsu_chk u_chk (
    .size              (lsu_size_i),
    .we                (lsu_we_i),
    .addr_lo           (lsu_addr_i[1:0]),
    .store_data        (lsu_data_i),
    .illegal           (illegal),
    .misaligned        (misaligned),
    .byte_mask         (unused_store_be),
    .store_data_masked (store_data_masked)
  );

  // Next-state, bus register updates and the combinational stall/exception outputs.
  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    mem_req_next  = mem_req_o;
    mem_we_next   = mem_we_o;
    mem_size_next = mem_size_o;
    mem_addr_next = mem_addr_o;
    mem_data_next = mem_data_o;
    lsu_data_next = lsu_data_o;
    lsu_exc_o     = 1'b0;
    stall_req_o   = 1'b0;

    case (state)
      LSU_IDLE: begin
        if (lsu_req_i) begin
          if (illegal || misaligned) begin
            lsu_exc_o = 1'b1;
          end else begin
            stall_req_o   = 1'b1;
            mem_req_next  = 1'b1;
            mem_we_next   = lsu_we_i;
            mem_size_next = lsu_size_i;
            mem_addr_next = lsu_addr_i;
            mem_data_next = store_data_masked;
            cnt_next      = CNT_W'(MEM_LATENCY - 1);
            state_next    = LSU_BUSY;
          end
        end
      end
      LSU_BUSY: begin
        stall_req_o = 1'b1;
        if (cnt == '0) begin
          if (!mem_we_o)
            lsu_data_next = mem_data_i;
          mem_req_next = 1'b0;
          mem_we_next  = 1'b0;
          state_next   = LSU_DONE;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      // The core retires here; its still-asserted request is the same instruction.
      LSU_DONE: state_next = LSU_IDLE;
      default:  state_next = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= LSU_IDLE;
      cnt        <= '0;
      mem_req_o  <= 1'b0;
      mem_we_o   <= 1'b0;
      mem_size_o <= 3'd0;
      mem_addr_o <= '0;
      mem_data_o <= '0;
      lsu_data_o <= '0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      mem_req_o  <= mem_req_next;
      mem_we_o   <= mem_we_next;
      mem_size_o <= mem_size_next;
      mem_addr_o <= mem_addr_next;
      mem_data_o <= mem_data_next;
      lsu_data_o <= lsu_data_next;
    end
  end

endmodule

// File: tb/tb_miriscv_lsu.sv
// Scoreboard bench for miriscv_lsu: a driver pushes expected responses, a negedge monitor checks them.
module tb_miriscv_lsu;
  import miriscv_pkg::*;

  localparam int unsigned LAT = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        lsu_req_i, lsu_we_i;
  logic [2:0]  lsu_size_i;
  logic [31:0] lsu_addr_i, lsu_data_i, lsu_data_o;
  logic        lsu_exc_o, stall_req_o, mem_req_o, mem_we_o;
  logic [2:0]  mem_size_o;
  logic [31:0] mem_addr_o, mem_data_o, mem_data_i;

  always #5 clk = ~clk;

  miriscv_lsu #(.MEM_LATENCY(LAT), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_size_i(lsu_size_i),
    .lsu_addr_i(lsu_addr_i), .lsu_data_i(lsu_data_i), .lsu_data_o(lsu_data_o),
    .lsu_exc_o(lsu_exc_o), .stall_req_o(stall_req_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_size_o(mem_size_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i)
  );

  typedef struct {
    logic        exc;
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  mem_bytes [256];
  logic [31:0] last_load;
  int unsigned n_total = 0, n_pass = 0;
  logic        mon_skip = 1'b0;

  // Byte-addressed little-endian memory that returns extended load data.
  function automatic logic [31:0] mem_read(input logic [31:0] a, input logic [2:0] sz);
    logic [7:0] b0, b1, b2, b3;
    b0 = mem_bytes[8'(a)];
    b1 = mem_bytes[8'(a + 32'd1)];
    b2 = mem_bytes[8'(a + 32'd2)];
    b3 = mem_bytes[8'(a + 32'd3)];
    case (sz)
      LDST_B:  return {{24{b0[7]}}, b0};
      LDST_H:  return {{16{b1[7]}}, b1, b0};
      LDST_BU: return {24'h0, b0};
      LDST_HU: return {16'h0, b1, b0};
      default: return {b3, b2, b1, b0};
    endcase
  endfunction

  assign mem_data_i = (mem_req_o && !mem_we_o) ? mem_read(mem_addr_o, mem_size_o) : 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Issue one access, hold it while stalled, release after the retire cycle.
  task automatic do_access(input logic we, input logic [2:0] size,
                           input logic [31:0] addr, input logic [31:0] data);
    exp_t e;
    logic ill, mis;
    int unsigned guard;
    ill = (size == 3'd3) || (size >= 3'd6) || (we && (size == 3'd4 || size == 3'd5));
    mis = 1'b0;
`ifdef MIRISCV_LSU_MISALIGN_CHECK_EN
    mis = ((size == 3'd1 || size == 3'd5) && addr[0]) || (size == 3'd2 && addr[1:0] != 2'b00);
`endif
    e.exc  = ill || mis;
    e.we   = we;
    e.size = size;
    e.addr = addr;
    case (size[1:0])
      2'd0:    e.wdata = data & 32'h0000_00FF;
      2'd1:    e.wdata = data & 32'h0000_FFFF;
      default: e.wdata = data;
    endcase
    if (e.exc || we) begin
      e.rdata = last_load;
      if (!e.exc)
        for (int i = 0; i < (1 << size[1:0]); i++)
          mem_bytes[8'(addr + 32'(i))] = data[8*i +: 8];
    end else begin
      e.rdata   = mem_read(addr, size);
      last_load = e.rdata;
    end
    sb.push_back(e);

    lsu_req_i  = 1'b1;
    lsu_we_i   = we;
    lsu_size_i = size;
    lsu_addr_i = addr;
    lsu_data_i = data;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (stall_req_o && guard < 40);
    if (guard >= 40) begin
      n_total++;
      $display("FAIL stall_timeout: stall held %0d cycles, required %0d", guard, LAT + 1);
    end
    @(posedge clk); #1;
    lsu_req_i = 1'b0;
  endtask

  // Monitor: observes bus/stall activity and compares with the scoreboard head.
  logic        prev_stall = 1'b0, unstable = 1'b0, we_viol = 1'b0;
  int unsigned req_cnt = 0, stall_cnt = 0;
  logic        cap_we;
  logic [2:0]  cap_size;
  logic [31:0] cap_addr, cap_data;

  always @(negedge clk) begin
    exp_t e;
    if (reset || mon_skip) begin
      prev_stall = 1'b0; req_cnt = 0; stall_cnt = 0; unstable = 1'b0; we_viol = 1'b0;
    end else begin
      if (mem_we_o && !mem_req_o) we_viol = 1'b1;
      if (lsu_exc_o) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL exc_unexpected: exception raised with no access outstanding");
        end else begin
          e = sb.pop_front();
          check("exc_flag", 32'(lsu_exc_o), 32'(e.exc));
          check("exc_stall", 32'(stall_req_o), 32'd0);
          check("exc_no_req", 32'(mem_req_o), 32'd0);
          check("exc_data_hold", lsu_data_o, e.rdata);
        end
      end
      if (stall_req_o) stall_cnt++;
      if (mem_req_o) begin
        if (req_cnt == 0) begin
          cap_we = mem_we_o; cap_size = mem_size_o; cap_addr = mem_addr_o; cap_data = mem_data_o;
        end else if (cap_we !== mem_we_o || cap_size !== mem_size_o ||
                     cap_addr !== mem_addr_o || cap_data !== mem_data_o) begin
          unstable = 1'b1;
        end
        req_cnt++;
      end
      if (prev_stall && !stall_req_o) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL done_unexpected: access retired with no access outstanding");
        end else begin
          e = sb.pop_front();
          check("done_exc", 32'(lsu_exc_o), 32'(e.exc));
          check("bus_we", 32'(cap_we), 32'(e.we));
          check("bus_size", 32'(cap_size), 32'(e.size));
          check("bus_addr", cap_addr, e.addr);
          if (e.we) check("bus_wdata", cap_data, e.wdata);
          check("req_cycles", req_cnt, LAT);
          check("stall_cycles", stall_cnt, LAT + 1);
          check("bus_stable", 32'(unstable), 32'd0);
          check("we_without_req", 32'(we_viol), 32'd0);
          check("done_req_low", 32'(mem_req_o), 32'd0);
          check("lsu_data", lsu_data_o, e.rdata);
        end
        req_cnt = 0; stall_cnt = 0; unstable = 1'b0; we_viol = 1'b0;
      end
      prev_stall = stall_req_o;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned seen, gap;
    lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_size_i = 3'd0; lsu_addr_i = '0; lsu_data_i = '0;
    for (int i = 0; i < 256; i++) mem_bytes[i] = 8'($urandom);
    last_load = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    check("rst_mem_req", 32'(mem_req_o), 32'd0);
    check("rst_mem_we", 32'(mem_we_o), 32'd0);
    check("rst_mem_size", 32'(mem_size_o), 32'd0);
    check("rst_mem_addr", mem_addr_o, 32'd0);
    check("rst_mem_data", mem_data_o, 32'd0);
    check("rst_lsu_data", lsu_data_o, 32'd0);
    check("rst_stall", 32'(stall_req_o), 32'd0);

    mem_bytes[8] = 8'hEF; mem_bytes[9] = 8'hBE; mem_bytes[10] = 8'hAD; mem_bytes[11] = 8'hDE;
    do_access(1'b0, LDST_W, 32'h8, 32'h0);
    do_access(1'b1, LDST_B, 32'h4, 32'h1234_5678);
    do_access(1'b0, LDST_W, 32'h6, 32'h0);
    do_access(1'b1, LDST_BU, 32'h10, $urandom);
    do_access(1'b0, 3'd7, 32'h10, 32'h0);
    do_access(1'b0, LDST_HU, 32'h2, 32'h0);
    do_access(1'b0, LDST_B, 32'h3, 32'h0);

    // Reset during the second busy cycle of a store.
    mon_skip   = 1'b1;
    lsu_req_i  = 1'b1; lsu_we_i = 1'b1; lsu_size_i = LDST_W;
    lsu_addr_i = 32'h20; lsu_data_i = $urandom;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_pre_req", 32'(mem_req_o), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_req_drop", 32'(mem_req_o), 32'd0);
    check("rst_we_drop", 32'(mem_we_o), 32'd0);
    lsu_req_i = 1'b0;
    @(negedge clk); @(negedge clk); reset = 1'b0;
    last_load = 32'h0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (mem_req_o || mem_we_o || stall_req_o) seen++;
    end
    check("rst_no_write", seen, 32'd0);
    mon_skip = 1'b0;
    @(posedge clk); #1;

    for (int n = 0; n < 300; n++) begin
      do_access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                32'($urandom_range(0, 63)), $urandom);
      gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      repeat (gap) begin @(posedge clk); #1; end
    end

    repeat (5) @(posedge clk);
    #1;
    check("sb_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
